// File: rtl/pcie_us_cq_bar_demux_pkg.sv
// Shared UltraScale PCIe CQ descriptor field offsets and demux types.
package pcie_us_cq_bar_demux_pkg;

  // CQ request descriptor fields, located in the first 128 bits of the first beat
  localparam int unsigned CQ_DESC_W       = 128;
  localparam int unsigned CQ_BAR_ID_LSB   = 112;
  localparam int unsigned CQ_BAR_ID_W     = 3;
  localparam int unsigned CQ_REQ_TYPE_LSB = 75;
  localparam int unsigned CQ_REQ_TYPE_W   = 4;

  // One claim bit per possible BAR ID
  localparam int unsigned BAR_MASK_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_DROP = 2'd2
  } cq_demux_state_t;

endpackage

// File: rtl/pcie_us_cq_reg_slice.sv
// Single-channel output register plus one-entry skid register.
// The upstream handshake is owned by the parent; s_valid is an accepted beat.
module pcie_us_cq_reg_slice #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             temp_valid_next_c
);

  logic [WIDTH-1:0] out_data_q;
  logic [WIDTH-1:0] temp_data_q;
  logic             out_valid_q;
  logic             temp_valid_q;
  logic             out_valid_d;
  logic             temp_valid_d;
  logic             load_out_in;
  logic             load_out_temp;
  logic             load_temp_in;

  // Decide where the incoming beat lands and whether the skid drains
  always_comb begin
    out_valid_d   = out_valid_q;
    temp_valid_d  = temp_valid_q;
    load_out_in   = 1'b0;
    load_out_temp = 1'b0;
    load_temp_in  = 1'b0;
    if (m_ready || !out_valid_q) begin
      if (temp_valid_q) begin
        load_out_temp = 1'b1;
        out_valid_d   = 1'b1;
        temp_valid_d  = s_valid;
        load_temp_in  = s_valid;
      end else begin
        out_valid_d = s_valid;
        load_out_in = s_valid;
      end
    end else if (s_valid) begin
      temp_valid_d = 1'b1;
      load_temp_in = 1'b1;
    end
  end

  // Valid flags, cleared by reset so buffered beats are discarded
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      temp_valid_q <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      temp_valid_q <= temp_valid_d;
    end
  end

  // Payload registers, only loaded when a beat is moved into them
  always_ff @(posedge clk) begin
    if (load_out_in) begin
      out_data_q <= s_data;
    end else if (load_out_temp) begin
      out_data_q <= temp_data_q;
    end
    if (load_temp_in) begin
      temp_data_q <= s_data;
    end
  end

  assign m_data            = out_data_q;
  assign m_valid           = out_valid_q;
  assign temp_valid_next_c = temp_valid_d;

endmodule

// File: rtl/pcie_us_cq_bar_demux.sv
// Routes CQ TLPs to one of M_COUNT outputs by descriptor BAR ID; unclaimed TLPs are dropped.
module pcie_us_cq_bar_demux
  import pcie_us_cq_bar_demux_pkg::*;
#(
  parameter int unsigned AXIS_PCIE_DATA_WIDTH    = 256,
  parameter int unsigned AXIS_PCIE_KEEP_WIDTH    = AXIS_PCIE_DATA_WIDTH / 32,
  parameter int unsigned AXIS_PCIE_CQ_USER_WIDTH = 85,
  parameter int unsigned M_COUNT                 = 2,
  parameter logic [M_COUNT*BAR_MASK_W-1:0] M_BAR_MASK = {M_COUNT{8'hff}}
) (
  input  logic                                       clk,
  input  logic                                       rst,

  input  logic [AXIS_PCIE_DATA_WIDTH-1:0]            s_axis_cq_tdata,
  input  logic [AXIS_PCIE_KEEP_WIDTH-1:0]            s_axis_cq_tkeep,
  input  logic                                       s_axis_cq_tvalid,
  output logic                                       s_axis_cq_tready,
  input  logic                                       s_axis_cq_tlast,
  input  logic [AXIS_PCIE_CQ_USER_WIDTH-1:0]         s_axis_cq_tuser,

  output logic [M_COUNT*AXIS_PCIE_DATA_WIDTH-1:0]    m_axis_cq_tdata,
  output logic [M_COUNT*AXIS_PCIE_KEEP_WIDTH-1:0]    m_axis_cq_tkeep,
  output logic [M_COUNT-1:0]                         m_axis_cq_tvalid,
  input  logic [M_COUNT-1:0]                         m_axis_cq_tready,
  output logic [M_COUNT-1:0]                         m_axis_cq_tlast,
  output logic [M_COUNT*AXIS_PCIE_CQ_USER_WIDTH-1:0] m_axis_cq_tuser,

  input  logic [M_COUNT-1:0]                         enable,
  output logic                                       status_drop
);

  localparam int unsigned DW        = AXIS_PCIE_DATA_WIDTH;
  localparam int unsigned KW        = AXIS_PCIE_KEEP_WIDTH;
  localparam int unsigned UW        = AXIS_PCIE_CQ_USER_WIDTH;
  localparam int unsigned PAYLOAD_W = DW + KW + UW + 1;
  localparam int unsigned SEL_W     = (M_COUNT > 1) ? $clog2(M_COUNT) : 1;

  // Descriptor must sit entirely in the first beat
  if (AXIS_PCIE_DATA_WIDTH != 128 && AXIS_PCIE_DATA_WIDTH != 256) begin : g_bad_width
    $error("pcie_us_cq_bar_demux: AXIS_PCIE_DATA_WIDTH must be 128 or 256");
  end
  if (M_COUNT < 1 || M_COUNT > 8) begin : g_bad_count
    $error("pcie_us_cq_bar_demux: M_COUNT must be 1..8");
  end

  cq_demux_state_t           state_q;
  cq_demux_state_t           state_d;
  logic [SEL_W-1:0]          sel_q;
  logic [SEL_W-1:0]          sel_d;
  logic [SEL_W-1:0]          enc_sel;
  logic                      enc_match;
  logic [SEL_W-1:0]          tgt_c;
  logic                      fwd_c;
  logic                      s_ready_q;
  logic                      ready_d;
  logic                      drop_q;
  logic                      drop_d;
  logic                      s_fire;
  logic [CQ_BAR_ID_W-1:0]    bar_id;
  logic [M_COUNT-1:0]        claim;
  logic [M_COUNT-1:0]        route_c;
  logic [M_COUNT-1:0]        sel_d_oh;
  logic [M_COUNT-1:0]        temp_valid_next;
  logic [PAYLOAD_W-1:0]      s_payload;

  assign s_fire    = s_axis_cq_tvalid && s_ready_q;
  assign bar_id    = s_axis_cq_tdata[CQ_BAR_ID_LSB +: CQ_BAR_ID_W];
  assign s_payload = {s_axis_cq_tlast, s_axis_cq_tuser, s_axis_cq_tkeep, s_axis_cq_tdata};

  // Per-output claim of the current BAR ID
  for (genvar i = 0; i < M_COUNT; i++) begin : g_claim
    logic [BAR_MASK_W-1:0] bar_mask;
    assign bar_mask = M_BAR_MASK[i*BAR_MASK_W +: BAR_MASK_W];
    assign claim[i] = enable[i] && bar_mask[bar_id];
  end

  // Priority encoder: lowest claiming output wins
  always_comb begin
    enc_match = 1'b0;
    enc_sel   = '0;
    for (int i = M_COUNT - 1; i >= 0; i--) begin
      if (claim[i]) begin
        enc_match = 1'b1;
        enc_sel   = SEL_W'(i);
      end
    end
  end

  // Frame FSM next state, beat routing and drop detection
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    tgt_c   = sel_q;
    fwd_c   = 1'b0;
    drop_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tgt_c = enc_sel;
        if (s_fire) begin
          if (enc_match) begin
            fwd_c = 1'b1;
            if (!s_axis_cq_tlast) begin
              state_d = ST_FWD;
              sel_d   = enc_sel;
            end
          end else begin
            drop_d = 1'b1;
            if (!s_axis_cq_tlast) begin
              state_d = ST_DROP;
            end
          end
        end
      end
      ST_FWD: begin
        if (s_fire) begin
          fwd_c = 1'b1;
          if (s_axis_cq_tlast) begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DROP: begin
        if (s_fire && s_axis_cq_tlast) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Next-cycle input ready: targeted skid empty, all skids empty in idle, always in drop
  always_comb begin
    ready_d = 1'b0;
    case (state_d)
      ST_DROP: ready_d = 1'b1;
      ST_FWD:  ready_d = ~|(temp_valid_next & sel_d_oh);
      default: ready_d = ~|temp_valid_next;
    endcase
  end

  // State, latched selection, registered ready and drop pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      s_ready_q <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      s_ready_q <= ready_d;
      drop_q    <= drop_d;
    end
  end

  assign s_axis_cq_tready = s_ready_q;
  assign status_drop      = drop_q;

  // One register slice per output; only the targeted one is loaded
  for (genvar i = 0; i < M_COUNT; i++) begin : g_out
    logic [PAYLOAD_W-1:0] m_payload;

    assign route_c[i]  = fwd_c && (tgt_c == SEL_W'(i));
    assign sel_d_oh[i] = (sel_d == SEL_W'(i));

    pcie_us_cq_reg_slice #(
      .WIDTH(PAYLOAD_W)
    ) u_slice (
      .clk               (clk),
      .rst               (rst),
      .s_data            (s_payload),
      .s_valid           (route_c[i]),
      .m_data            (m_payload),
      .m_valid           (m_axis_cq_tvalid[i]),
      .m_ready           (m_axis_cq_tready[i]),
      .temp_valid_next_c (temp_valid_next[i])
    );

    assign m_axis_cq_tdata[i*DW +: DW] = m_payload[DW-1:0];
    assign m_axis_cq_tkeep[i*KW +: KW] = m_payload[DW +: KW];
    assign m_axis_cq_tuser[i*UW +: UW] = m_payload[DW+KW +: UW];
    assign m_axis_cq_tlast[i]          = m_payload[PAYLOAD_W-1];
  end

endmodule
